memory: RTL and testbench



---
 rtl/memory.sv | 119 +++++++++++
 tb/tb_memory.sv | 126 ++++++++++++
 2 files changed

// File: rtl/memory.sv
// Data-memory stage: word-organised RAM with big-endian byte/halfword loads and stores.
// Optional MEMORY_ALIGN_CHECK_EN adds align_err_o and blocks misaligned stores.
module memory #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [31:0] alu_i,
  input  logic [31:0] addr_i,
  output logic [31:0] write_o
`ifdef MEMORY_ALIGN_CHECK_EN
  ,
  output logic        align_err_o
`endif
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic [31:0]           ram [WORDS];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           wr_data;
  logic                  wr_en;
  logic                  wr_commit;

  // Upper address bits are dropped, so addresses wrap around the RAM size.
  assign word_idx = alu_i[DEPTH_LOG2+1:2];
  assign lane     = alu_i[1:0];
  assign rd_word  = ram[word_idx];
  assign rd_half  = alu_i[1] ? rd_word[15:0] : rd_word[31:16];

  always_comb begin
    unique case (lane)
      2'd0:    rd_byte = rd_word[31:24];
      2'd1:    rd_byte = rd_word[23:16];
      2'd2:    rd_byte = rd_word[15:8];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    write_o = alu_i;
    case (op)
      OP_LB:   write_o = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  write_o = {24'h0, rd_byte};
      OP_LH:   write_o = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  write_o = {16'h0, rd_half};
      OP_LW:   write_o = rd_word;
      default: write_o = alu_i;
    endcase
  end

  // Partial stores merge into the current word so untouched lanes keep their data.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = rd_word;
    case (op)
      OP_SB: begin
        wr_en = 1'b1;
        unique case (lane)
          2'd0:    wr_data[31:24] = addr_i[7:0];
          2'd1:    wr_data[23:16] = addr_i[7:0];
          2'd2:    wr_data[15:8]  = addr_i[7:0];
          default: wr_data[7:0]   = addr_i[7:0];
        endcase
      end
      OP_SH: begin
        wr_en = 1'b1;
        if (alu_i[1]) wr_data[15:0]  = addr_i[15:0];
        else          wr_data[31:16] = addr_i[15:0];
      end
      OP_SW: begin
        wr_en   = 1'b1;
        wr_data = addr_i;
      end
      default: wr_en = 1'b0;
    endcase
  end

`ifdef MEMORY_ALIGN_CHECK_EN
  always_comb begin
    align_err_o = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: align_err_o = alu_i[0];
      OP_LW, OP_SW:         align_err_o = |alu_i[1:0];
      default:              align_err_o = 1'b0;
    endcase
  end

  assign wr_commit = wr_en & ~align_err_o;
`else
  assign wr_commit = wr_en;
`endif

  // NOTE: the RAM is cleared on reset, so it is built from flops rather than a RAM macro;
  // non-blocking updates give read-before-write for a same-cycle load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= '0;
    end else if (wr_commit) begin
      ram[word_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory stage: expected write_o values are queued when
// stimulus is applied and popped/compared once the combinational output settles.
module tb_memory;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op;
  logic [31:0] alu_i;
  logic [31:0] addr_i;
  logic [31:0] write_o;
`ifdef MEMORY_ALIGN_CHECK_EN
  logic        align_err_o;
`endif

  memory #(.DEPTH_LOG2(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (op),
    .alu_i   (alu_i),
    .addr_i  (addr_i),
    .write_o (write_o)
`ifdef MEMORY_ALIGN_CHECK_EN
    ,
    .align_err_o (align_err_o)
`endif
  );

  localparam logic [5:0] LB   = 6'b100000;
  localparam logic [5:0] LH   = 6'b100001;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] LBU  = 6'b100100;
  localparam logic [5:0] LHU  = 6'b100101;
  localparam logic [5:0] SB   = 6'b101000;
  localparam logic [5:0] SH   = 6'b101001;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t scoreboard[$];
  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction at the falling edge, queue its expected write_o and
  // compare after settling; a store commits at the following rising edge.
  task automatic step(input logic [5:0] o, input logic [31:0] alu, input logic [31:0] din,
                      input logic [31:0] exp, input string tag);
    sb_entry_t e;
    @(negedge clk);
    op     = o;
    alu_i  = alu;
    addr_i = din;
    e.tag  = tag;
    e.exp  = exp;
    scoreboard.push_back(e);
    #2;
    n_checks++;
    if (scoreboard.size() == 0) begin
      $error("FAIL %s: scoreboard empty, got %h", tag, write_o);
    end else begin
      e = scoreboard.pop_front();
      assert (write_o === e.exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", e.tag, write_o, e.exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    op     = ADDI;
    alu_i  = '0;
    addr_i = '0;
    repeat (2) @(posedge clk);

    step(LW, 32'h10, 32'h0, 32'h0000_0000, "reset_lw");
    #1 rst_n = 1'b1;

    step(SW,  32'h8, 32'h1234_5678, 32'h0000_0008, "sw_passthru");
    step(LW,  32'h8, 32'h0, 32'h1234_5678, "lw_after_sw");
    step(LB,  32'h9, 32'h0, 32'h0000_0034, "lb_lane1");
    step(LH,  32'hA, 32'h0, 32'h0000_5678, "lh_low_half");

    step(SB,  32'hB, 32'hF0, 32'h0000_000B, "sb_passthru");
    step(LB,  32'hB, 32'h0, 32'hFFFF_FFF0, "lb_sign");
    step(LBU, 32'hB, 32'h0, 32'h0000_00F0, "lbu_zero");
    step(LW,  32'h8, 32'h0, 32'h1234_56F0, "lw_after_sb");

    step(SH,  32'h8, 32'h9ABC, 32'h0000_0008, "sh_passthru");
    step(LH,  32'h8, 32'h0, 32'hFFFF_9ABC, "lh_sign");
    step(LHU, 32'h8, 32'h0, 32'h0000_9ABC, "lhu_zero");
    step(LW,  32'h8, 32'h0, 32'h9ABC_56F0, "lw_after_sh");

    step(ADDI, 32'hA, 32'h4925, 32'h0000_000A, "addi_passthru");
    step(LW,   32'h8, 32'h0, 32'h9ABC_56F0, "lw_after_addi");
    step(LW,   32'h0, 32'h0, 32'h0000_0000, "lw_word0_clear");

    step(SW,  32'h400, 32'hCAFE_BABE, 32'h0000_0400, "sw_wrap");
    step(LW,  32'h0, 32'h0, 32'hCAFE_BABE, "lw_wrap");
    step(LW,  32'hFFFF_FC08, 32'h0, 32'h9ABC_56F0, "lw_high_bits");
    step(LH,  32'h3, 32'h0, 32'hFFFF_BABE, "lh_odd_ignored");
    step(LB,  32'h1, 32'h0, 32'hFFFF_FFFE, "lb_lane1_word0");
    step(LBU, 32'h2, 32'h0, 32'h0000_00BA, "lbu_lane2");

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    step(LW,  32'h8, 32'h0, 32'h0000_0000, "lw_in_reset");
    step(SW,  32'h10, 32'hDEAD_BEEF, 32'h0000_0010, "sw_in_reset");
    step(LW,  32'h10, 32'h0, 32'h0000_0000, "sw_ignored_in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(SW,  32'h14, 32'h1122_3344, 32'h0000_0014, "sw_after_release");
    step(LW,  32'h14, 32'h0, 32'h1122_3344, "lw_after_release");
    step(LW,  32'h10, 32'h0, 32'h0000_0000, "lw_reset_cleared");
    step(LW,  32'h0, 32'h0, 32'h0000_0000, "lw_word0_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
